serial_pattern_tx: RTL and testbench

Moore-style serial pattern transmitter that serialises a parallel bit pattern of programmable length onto a single-bit line, MSB of the active field first. It is the stimulus/transmit end for the lab FSM sequence detectors (e.g. generating "011" frames into a 1-bit `din` input) and sits between a control source (bench or CPU-style register) and any serial consumer. All outputs are registered or decoded from the current state only; none depend combinationally on inputs.

---
 rtl/serial_pattern_tx_if.sv | 15 +
 rtl/serial_pattern_tx.sv | 88 ++++++++
 tb/tb_serial_pattern_tx.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_tx_if.sv
// serial_pattern_tx_if: control inputs and serial outputs of serial_pattern_tx.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8
);
  logic start;
  logic [WIDTH-1:0] pattern;
  logic [$clog2(WIDTH+1)-1:0] len;
  logic repeat_req;
  logic dout;
  logic dval;
  logic busy;
  logic done;
  modport master (output start, pattern, len, repeat_req, input dout, dval, busy, done);
  modport slave (input start, pattern, len, repeat_req, output dout, dval, busy, done);
endinterface

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first serialiser of a programmable-length pattern followed by a fixed idle gap.
// Define SERIAL_PATTERN_TX_REPEAT_EN to let repeat_req resend the latched frame without a new start.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP = 2
) (
  input logic clk,
  input logic n_rst,
  serial_pattern_tx_if.slave bus
);
  localparam int LW = $clog2(WIDTH + 1);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP_S} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [LW-1:0] cnt_q, cnt_d, len_q, len_d, len_eff;
  logic [GW-1:0] gap_q, gap_d;
  logic rep_q, rep_d, rep, bit_sel;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
  assign rep = bus.repeat_req;
`else
  logic unused_repeat;
  assign unused_repeat = bus.repeat_req;
  assign rep = 1'b0;
`endif
  assign len_eff = (bus.len == '0 || bus.len > LW'(WIDTH)) ? LW'(WIDTH) : bus.len;
  // the shadow stays intact so a repeated frame can be resent from it
  always_comb begin
    bit_sel = 1'b0;
    for (int i = 0; i < WIDTH; i++) if (cnt_q == LW'(i + 1)) bit_sel = shadow_q[i];
  end
  always_comb begin
    state_d = state_q;
    shadow_d = shadow_q;
    cnt_d = cnt_q;
    len_d = len_q;
    gap_d = gap_q;
    rep_d = rep_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SHIFT;
        shadow_d = bus.pattern;
        cnt_d = len_eff;
        len_d = len_eff;
      end
      SHIFT: begin
        cnt_d = cnt_q - LW'(1);
        if (cnt_q == LW'(1)) state_d = DONE;
      end
      DONE: begin
        rep_d = rep;
        if (GAP > 0) begin
          state_d = GAP_S;
          gap_d = GW'(GAP - 1);
        end else if (rep) begin
          state_d = SHIFT;
          cnt_d = len_q;
        end else state_d = IDLE;
      end
      GAP_S: if (gap_q == '0) begin
        state_d = rep_q ? SHIFT : IDLE;
        cnt_d = len_q;
      end else gap_d = gap_q - GW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      shadow_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      gap_q <= '0;
      rep_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shadow_q <= shadow_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      gap_q <= gap_d;
      rep_q <= rep_d;
    end
  end
  assign bus.dout = state_q == SHIFT && bit_sel;
  assign bus.dval = state_q == SHIFT;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: two instances (GAP=2, GAP=0) checked cycle by cycle against a queue-based frame model.
module tb_serial_pattern_tx;
  localparam int W = 8;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  typedef logic [3:0] vq_t[$];
  logic clk = 1'b0, n_rst = 1'b0, start = 1'b0, repeat_req = 1'b0;
  logic [W-1:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] o0, o1;
  logic [W-1:0] m_pat[2];
  logic [3:0] m_len[2];
  vq_t q0, q1;
  int total = 0, bad = 0;

  serial_pattern_tx_if #(.WIDTH(W)) bus0 (), bus1 ();
  assign bus0.start = start;
  assign bus0.pattern = pattern;
  assign bus0.len = len;
  assign bus0.repeat_req = repeat_req;
  assign bus1.start = start;
  assign bus1.pattern = pattern;
  assign bus1.len = len;
  assign bus1.repeat_req = repeat_req;
  serial_pattern_tx #(.WIDTH(W), .GAP(2)) dut0 (.clk(clk), .n_rst(n_rst), .bus(bus0));
  serial_pattern_tx #(.WIDTH(W), .GAP(0)) dut1 (.clk(clk), .n_rst(n_rst), .bus(bus1));
  assign o0 = {bus0.dout, bus0.dval, bus0.busy, bus0.done};
  assign o1 = {bus1.dout, bus1.dval, bus1.busy, bus1.done};

  always #5 clk = ~clk;

  // expected per-cycle {dout,dval,busy,done} for one whole frame, gap included
  function automatic vq_t frame(logic [W-1:0] pat, logic [3:0] ln, int gap);
    vq_t f;
    int l;
    l = (ln == 0 || ln > W) ? W : int'(ln);
    for (int i = l - 1; i >= 0; i--) f.push_back({pat[i], 3'b110});
    f.push_back(4'b0011);
    for (int i = 0; i < gap; i++) f.push_back(4'b0010);
    return f;
  endfunction

  function automatic logic [3:0] head(int i);
    if (i == 0) return q0.size() != 0 ? q0[0] : 4'h0;
    return q1.size() != 0 ? q1[0] : 4'h0;
  endfunction

  initial forever begin
    logic [3:0] cur;
    @(posedge clk or negedge n_rst);
    if (!n_rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() == 0) begin
        if (start) begin
          m_pat[0] = pattern;
          m_len[0] = len;
          q0 = frame(pattern, len, 2);
        end
      end else begin
        cur = q0.pop_front();
        if (cur == 4'b0011 && REP_EN && repeat_req) q0 = {q0, frame(m_pat[0], m_len[0], 2)};
      end
      if (q1.size() == 0) begin
        if (start) begin
          m_pat[1] = pattern;
          m_len[1] = len;
          q1 = frame(pattern, len, 0);
        end
      end else begin
        cur = q1.pop_front();
        if (cur == 4'b0011 && REP_EN && repeat_req) q1 = {q1, frame(m_pat[1], m_len[1], 0)};
      end
    end
  end

  task automatic test_reset();
    n_rst = 1'b0;
    start = 1'b1;
    pattern = 8'h5A;
    len = 4'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total += 2;
      if (o0 !== 4'h0) begin bad++; $display("FAIL reset_hold_g2 got=%b want=0000", o0); end
      if (o1 !== 4'h0) begin bad++; $display("FAIL reset_hold_g0 got=%b want=0000", o1); end
    end
    n_rst = 1'b1;
    start = 1'b0;
    pattern = 8'h05;
    @(negedge clk);
    total += 2;
    if (o0 !== head(0)) begin bad++; $display("FAIL reset_idle_g2 got=%b want=%b", o0, head(0)); end
    if (o1 !== head(1)) begin bad++; $display("FAIL reset_idle_g0 got=%b want=%b", o1, head(1)); end
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      total += 2;
      if (o0 !== head(0)) begin bad++; $display("FAIL reset_frame_g2 c=%0d got=%b want=%b", c, o0, head(0)); end
      if (o1 !== head(1)) begin bad++; $display("FAIL reset_frame_g0 c=%0d got=%b want=%b", c, o1, head(1)); end
      if (c == 1) begin
        total++;
        if (o0 !== 4'b1110) begin bad++; $display("FAIL reset_first_bit got=%b want=1110", o0); end
        start = 1'b0;
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] ds, vs, bs, dn;
    start = 1'b1;
    pattern = 8'h03;
    len = 4'd3;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      total += 2;
      if (o0 !== head(0)) begin bad++; $display("FAIL basic_g2 c=%0d got=%b want=%b", c, o0, head(0)); end
      if (o1 !== head(1)) begin bad++; $display("FAIL basic_g0 c=%0d got=%b want=%b", c, o1, head(1)); end
      ds = {ds[6:0], o0[3]};
      vs = {vs[6:0], o0[2]};
      bs = {bs[6:0], o0[1]};
      dn = {dn[6:0], o0[0]};
      start = 1'b0;
    end
    total += 4;
    if (ds !== 8'b0110_0000) begin bad++; $display("FAIL basic_dout got=%b want=01100000", ds); end
    if (vs !== 8'b1110_0000) begin bad++; $display("FAIL basic_dval got=%b want=11100000", vs); end
    if (bs !== 8'b1111_1100) begin bad++; $display("FAIL basic_busy got=%b want=11111100", bs); end
    if (dn !== 8'b0001_0000) begin bad++; $display("FAIL basic_done got=%b want=00010000", dn); end
  endtask

  task automatic test_len_clamp();
    logic [7:0] ds0, ds1;
    logic [3:0] lens[2];
    lens[0] = 4'd0;
    lens[1] = 4'd15;
    for (int n = 0; n < 2; n++) begin
      start = 1'b1;
      pattern = 8'hA5;
      len = lens[n];
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        total += 2;
        if (o0 !== head(0)) begin bad++; $display("FAIL clamp_g2 len=%0d c=%0d got=%b want=%b", len, c, o0, head(0)); end
        if (o1 !== head(1)) begin bad++; $display("FAIL clamp_g0 len=%0d c=%0d got=%b want=%b", len, c, o1, head(1)); end
        if (c <= 8) begin
          ds0 = {ds0[6:0], o0[3]};
          ds1 = {ds1[6:0], o1[3]};
        end
        start = 1'b0;
      end
      total += 2;
      if (ds0 !== 8'hA5) begin bad++; $display("FAIL clamp_bits_g2 len=%0d got=%h want=a5", len, ds0); end
      if (ds1 !== 8'hA5) begin bad++; $display("FAIL clamp_bits_g0 len=%0d got=%h want=a5", len, ds1); end
    end
  endtask

  task automatic test_ignore();
    logic [W-1:0] p;
    logic [5:0] ds;
    p = W'($urandom);
    start = 1'b1;
    pattern = p;
    len = 4'd6;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      total += 2;
      if (o0 !== head(0)) begin bad++; $display("FAIL ignore_g2 c=%0d got=%b want=%b", c, o0, head(0)); end
      if (o1 !== head(1)) begin bad++; $display("FAIL ignore_g0 c=%0d got=%b want=%b", c, o1, head(1)); end
      if (c <= 6) ds = {ds[4:0], o0[3]};
      if (c == 9) begin
        total++;
        if (o1 !== 4'h0) begin bad++; $display("FAIL ignore_done_start_g0 got=%b want=0000", o1); end
      end
      if (c == 11) begin
        total++;
        if (o0 !== 4'h0) begin bad++; $display("FAIL ignore_done_start_g2 got=%b want=0000", o0); end
      end
      start = (c == 2 || c == 7);
      if (c == 2) begin
        pattern = ~p;
        len = 4'd3;
      end
    end
    total++;
    if (ds !== p[5:0]) begin bad++; $display("FAIL ignore_bits got=%b want=%b", ds, p[5:0]); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    pattern = W'($urandom);
    len = 4'd6;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      total += 2;
      if (o0 !== head(0)) begin bad++; $display("FAIL rstmid_pre_g2 c=%0d got=%b want=%b", c, o0, head(0)); end
      if (o1 !== head(1)) begin bad++; $display("FAIL rstmid_pre_g0 c=%0d got=%b want=%b", c, o1, head(1)); end
      start = 1'b0;
    end
    #2 n_rst = 1'b0;
    #1;
    total += 2;
    if (o0 !== 4'h0) begin bad++; $display("FAIL rstmid_async_g2 got=%b want=0000", o0); end
    if (o1 !== 4'h0) begin bad++; $display("FAIL rstmid_async_g0 got=%b want=0000", o1); end
    @(negedge clk);
    n_rst = 1'b1;
    start = 1'b1;
    pattern = W'($urandom);
    len = 4'd4;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      total += 2;
      if (o0 !== head(0)) begin bad++; $display("FAIL rstmid_post_g2 c=%0d got=%b want=%b", c, o0, head(0)); end
      if (o1 !== head(1)) begin bad++; $display("FAIL rstmid_post_g0 c=%0d got=%b want=%b", c, o1, head(1)); end
      if (c == 1) begin
        total++;
        if (o0[2] !== 1'b1) begin bad++; $display("FAIL rstmid_restart dval=%b want=1", o0[2]); end
      end
      start = 1'b0;
    end
  endtask

  task automatic test_repeat();
    int n0, n1;
    n0 = 0;
    n1 = 0;
    repeat_req = 1'b1;
    start = 1'b1;
    pattern = 8'h03;
    len = 4'd3;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      total += 2;
      if (o0 !== head(0)) begin bad++; $display("FAIL repeat_g2 c=%0d got=%b want=%b", c, o0, head(0)); end
      if (o1 !== head(1)) begin bad++; $display("FAIL repeat_g0 c=%0d got=%b want=%b", c, o1, head(1)); end
      n0 += int'(o0[0]);
      n1 += int'(o1[0]);
      start = 1'b0;
    end
    total += 2;
    if (n1 !== (REP_EN ? 3 : 1)) begin bad++; $display("FAIL repeat_done_g0 got=%0d want=%0d", n1, REP_EN ? 3 : 1); end
    if (n0 !== (REP_EN ? 2 : 1)) begin bad++; $display("FAIL repeat_done_g2 got=%0d want=%0d", n0, REP_EN ? 2 : 1); end
    repeat_req = 1'b0;
    for (int c = 0; c < 40 && (o0 !== 4'h0 || o1 !== 4'h0); c++) begin
      @(negedge clk);
      total += 2;
      if (o0 !== head(0)) begin bad++; $display("FAIL repeat_drain_g2 got=%b want=%b", o0, head(0)); end
      if (o1 !== head(1)) begin bad++; $display("FAIL repeat_drain_g0 got=%b want=%b", o1, head(1)); end
    end
    total++;
    if ({o0, o1} !== 8'h00) begin bad++; $display("FAIL repeat_stop got=%b_%b want=0000_0000", o0, o1); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 440; c++) begin
      @(negedge clk);
      total += 2;
      if (o0 !== head(0)) begin bad++; $display("FAIL random_g2 c=%0d got=%b want=%b", c, o0, head(0)); end
      if (o1 !== head(1)) begin bad++; $display("FAIL random_g0 c=%0d got=%b want=%b", c, o1, head(1)); end
      start = c < 400 && $urandom_range(0, 3) == 0;
      repeat_req = c < 400 && $urandom_range(0, 7) == 0;
      pattern = W'($urandom);
      len = 4'($urandom_range(0, 15));
    end
    total++;
    if ({o0, o1} !== 8'h00) begin bad++; $display("FAIL random_idle got=%b_%b want=0000_0000", o0, o1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_clamp();
    test_ignore();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
